// File: rtl/sram_req_arbiter.sv
// Shares one downstream SRAM-like port between the fetch and memory requesters.
// Tracks outstanding transactions in an owner FIFO and steers in-order responses back.
module sram_req_arbiter #(
    parameter int MAX_OUTST    = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         resetn,

    input  logic                         inst_sram_req,
    input  logic                         inst_sram_wr,
    input  logic [1:0]                   inst_sram_size,
    input  logic [3:0]                   inst_sram_wstrb,
    input  logic [31:0]                  inst_sram_addr,
    input  logic [31:0]                  inst_sram_wdata,
    output logic                         inst_sram_addr_ok,
    output logic                         inst_sram_data_ok,
    output logic [31:0]                  inst_sram_rdata,

    input  logic                         data_sram_req,
    input  logic                         data_sram_wr,
    input  logic [1:0]                   data_sram_size,
    input  logic [3:0]                   data_sram_wstrb,
    input  logic [31:0]                  data_sram_addr,
    input  logic [31:0]                  data_sram_wdata,
    output logic                         data_sram_addr_ok,
    output logic                         data_sram_data_ok,
    output logic [31:0]                  data_sram_rdata,

    output logic                         mem_req,
    output logic                         mem_wr,
    output logic [1:0]                   mem_size,
    output logic [3:0]                   mem_wstrb,
    output logic [31:0]                  mem_addr,
    output logic [31:0]                  mem_wdata,
    input  logic                         mem_addr_ok,
    input  logic                         mem_data_ok,
    input  logic [31:0]                  mem_rdata,

    output logic [$clog2(MAX_OUTST):0]   outst_cnt,
    output logic                         proto_err
);

    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(MAX_OUTST);
    localparam logic [STV_W-1:0] STV_MAX    = STV_W'(STARVE_LIMIT);
    localparam logic             OWNER_INST = 1'b0;
    localparam logic             OWNER_DATA = 1'b1;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_INST,
        GNT_DATA
    } grant_e;

    logic [MAX_OUTST-1:0] owner_q, owner_d;
    logic [PTR_W-1:0]     head_q, head_d;
    logic [PTR_W-1:0]     tail_q, tail_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [STV_W-1:0]     starve_q, starve_d;
    logic                 proto_err_q, proto_err_d;

    grant_e grant;
    logic   full;
    logic   empty;
    logic   force_inst;
    logic   accept;
    logic   inst_accept;
    logic   data_accept;
    logic   resp_valid;
    logic   head_owner;

    assign full       = (cnt_q == FULL_CNT);
    assign empty      = (cnt_q == '0);
    assign force_inst = inst_sram_req && (starve_q == STV_MAX);

    // Data normally wins; a starved fetch overrides it. Nothing is granted while full,
    // even if a response frees a slot this same cycle.
    always_comb begin
        grant = GNT_NONE;
        if (resetn && !full) begin
            if (data_sram_req && !force_inst) begin
                grant = GNT_DATA;
            end else if (inst_sram_req) begin
                grant = GNT_INST;
            end
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_wr    = 1'b0;
        mem_size  = 2'b0;
        mem_wstrb = 4'b0;
        mem_addr  = 32'b0;
        mem_wdata = 32'b0;
        case (grant)
            GNT_INST: begin
                mem_req   = 1'b1;
                mem_wr    = inst_sram_wr;
                mem_size  = inst_sram_size;
                mem_wstrb = inst_sram_wstrb;
                mem_addr  = inst_sram_addr;
                mem_wdata = inst_sram_wdata;
            end
            GNT_DATA: begin
                mem_req   = 1'b1;
                mem_wr    = data_sram_wr;
                mem_size  = data_sram_size;
                mem_wstrb = data_sram_wstrb;
                mem_addr  = data_sram_addr;
                mem_wdata = data_sram_wdata;
            end
            default: begin
            end
        endcase
    end

    assign accept      = mem_req && mem_addr_ok;
    assign inst_accept = accept && (grant == GNT_INST);
    assign data_accept = accept && (grant == GNT_DATA);

    assign inst_sram_addr_ok = inst_accept;
    assign data_sram_addr_ok = data_accept;

    // Responses come back strictly in acceptance order, so the FIFO head names the owner.
    assign resp_valid = resetn && mem_data_ok && !empty;
    assign head_owner = owner_q[head_q];

    assign inst_sram_data_ok = resp_valid && (head_owner == OWNER_INST);
    assign data_sram_data_ok = resp_valid && (head_owner == OWNER_DATA);
    assign inst_sram_rdata   = resetn ? mem_rdata : 32'b0;
    assign data_sram_rdata   = resetn ? mem_rdata : 32'b0;

    always_comb begin
        owner_d = owner_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;
        if (accept) begin
            owner_d[tail_q] = (grant == GNT_DATA) ? OWNER_DATA : OWNER_INST;
            tail_d          = tail_q + PTR_W'(1);
        end
        if (resp_valid) begin
            head_d = head_q + PTR_W'(1);
        end
        case ({accept, resp_valid})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        starve_d = starve_q;
        if (!inst_sram_req || inst_accept) begin
            starve_d = '0;
        end else if (data_accept && (starve_q != STV_MAX)) begin
            starve_d = starve_q + STV_W'(1);
        end
    end

    assign proto_err_d = proto_err_q || (mem_data_ok && empty);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            starve_q    <= '0;
            proto_err_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign outst_cnt = cnt_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based model of grants, ownership and starvation.
module tb_sram_req_arbiter;

    localparam int MAX_OUTST    = 4;
    localparam int STARVE_LIMIT = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic [2:0]  outst_cnt;
    logic        proto_err;

    int errors = 0;
    int checks = 0;

    bit owner_m[$];
    int starve_m;
    bit perr_m;

    bit          e_gi, e_gd, e_iaok, e_daok, e_idok, e_ddok;
    logic        e_wr;
    logic [1:0]  e_size;
    logic [3:0]  e_wstrb;
    logic [31:0] e_addr, e_wdata;

    sram_req_arbiter #(.MAX_OUTST(MAX_OUTST), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
        .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .outst_cnt(outst_cnt), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        owner_m.delete();
        starve_m = 0;
        perr_m   = 1'b0;
    endtask

    // Expected combinational behaviour for the current inputs and model state.
    task automatic model_comb();
        bit full, forced;
        full   = (owner_m.size() >= MAX_OUTST);
        forced = inst_sram_req && (starve_m == STARVE_LIMIT);
        e_gd   = !full && data_sram_req && !forced;
        e_gi   = !full && inst_sram_req && !e_gd;
        e_wr    = e_gd ? data_sram_wr    : (e_gi ? inst_sram_wr    : 1'b0);
        e_size  = e_gd ? data_sram_size  : (e_gi ? inst_sram_size  : 2'b0);
        e_wstrb = e_gd ? data_sram_wstrb : (e_gi ? inst_sram_wstrb : 4'b0);
        e_addr  = e_gd ? data_sram_addr  : (e_gi ? inst_sram_addr  : 32'b0);
        e_wdata = e_gd ? data_sram_wdata : (e_gi ? inst_sram_wdata : 32'b0);
        e_iaok = e_gi && mem_addr_ok;
        e_daok = e_gd && mem_addr_ok;
        e_idok = mem_data_ok && (owner_m.size() > 0) && (owner_m[0] == 1'b0);
        e_ddok = mem_data_ok && (owner_m.size() > 0) && (owner_m[0] == 1'b1);
    endtask

    task automatic model_clock();
        if (mem_data_ok) begin
            if (owner_m.size() == 0) perr_m = 1'b1;
            else void'(owner_m.pop_front());
        end
        if (e_iaok || e_daok) owner_m.push_back(e_gd);
        if (e_iaok || !inst_sram_req) starve_m = 0;
        else if (e_daok && starve_m < STARVE_LIMIT) starve_m = starve_m + 1;
    endtask

    task automatic apply(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                         input bit dw, input bit mao, input bit mdo, input logic [31:0] rd);
        inst_sram_req   = ir;
        inst_sram_wr    = 1'b0;
        inst_sram_size  = 2'd2;
        inst_sram_wstrb = 4'hF;
        inst_sram_addr  = ia;
        inst_sram_wdata = 32'h0;
        data_sram_req   = dr;
        data_sram_wr    = dw;
        data_sram_size  = 2'd2;
        data_sram_wstrb = dw ? 4'hF : 4'h0;
        data_sram_addr  = da;
        data_sram_wdata = ~da;
        mem_addr_ok     = mao;
        mem_data_ok     = mdo;
        mem_rdata       = rd;
        #1;
        model_comb();
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < MAX_OUTST + 2 && owner_m.size() > 0; k++) begin
            apply(0, 0, 0, 0, 0, 0, 1, $urandom);
            tick();
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (outst_cnt !== 3'd0) begin errors++; $display("[TB] FAIL drain_cnt: got %0d want 0", outst_cnt); end
    endtask

    task automatic test_reset();
        inst_sram_req = 1; data_sram_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        inst_sram_addr = 32'h1C000000; data_sram_addr = 32'h100; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk); #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL rst_mem_req: got %b want 0", mem_req); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL rst_mem_addr: got %h want 0", mem_addr); end
        checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b00) begin errors++; $display("[TB] FAIL rst_addr_ok: got %b want 00", {inst_sram_addr_ok, data_sram_addr_ok}); end
        checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin errors++; $display("[TB] FAIL rst_data_ok: got %b want 00", {inst_sram_data_ok, data_sram_data_ok}); end
        checks++; if (inst_sram_rdata !== 32'h0) begin errors++; $display("[TB] FAIL rst_rdata: got %h want 0", inst_sram_rdata); end
        checks++; if (outst_cnt !== 3'd0) begin errors++; $display("[TB] FAIL rst_cnt: got %0d want 0", outst_cnt); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_proto_err: got %b want 0", proto_err); end
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        resetn = 1'b1;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        apply(1, 32'h1C000000, 0, 0, 0, 1, 0, 0);
        checks++; if (inst_sram_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL fetch_addr_ok: got %b want 1", inst_sram_addr_ok); end
        checks++; if (mem_addr !== 32'h1C000000) begin errors++; $display("[TB] FAIL fetch_mem_addr: got %h want 1c000000", mem_addr); end
        checks++; if (data_sram_addr_ok !== 1'b0) begin errors++; $display("[TB] FAIL fetch_data_addr_ok: got %b want 0", data_sram_addr_ok); end
        tick();
        apply(0, 0, 0, 0, 0, 0, 1, 32'h02800000);
        checks++; if (inst_sram_data_ok !== 1'b1) begin errors++; $display("[TB] FAIL fetch_data_ok: got %b want 1", inst_sram_data_ok); end
        checks++; if (inst_sram_rdata !== 32'h02800000) begin errors++; $display("[TB] FAIL fetch_rdata: got %h want 02800000", inst_sram_rdata); end
        checks++; if (data_sram_data_ok !== 1'b0) begin errors++; $display("[TB] FAIL fetch_other_ok: got %b want 0", data_sram_data_ok); end
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (outst_cnt !== 3'd0) begin errors++; $display("[TB] FAIL fetch_cnt: got %0d want 0", outst_cnt); end
    endtask

    task automatic test_priority_order();
        apply(1, 32'h1C000010, 1, 32'h00001000, 0, 1, 0, 0);
        checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b01) begin errors++; $display("[TB] FAIL prio_first: got %b want 01", {inst_sram_addr_ok, data_sram_addr_ok}); end
        checks++; if (mem_addr !== 32'h00001000) begin errors++; $display("[TB] FAIL prio_addr1: got %h want 00001000", mem_addr); end
        tick();
        apply(1, 32'h1C000010, 0, 0, 0, 1, 0, 0);
        checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b10) begin errors++; $display("[TB] FAIL prio_second: got %b want 10", {inst_sram_addr_ok, data_sram_addr_ok}); end
        checks++; if (mem_addr !== 32'h1C000010) begin errors++; $display("[TB] FAIL prio_addr2: got %h want 1c000010", mem_addr); end
        tick();
        apply(0, 0, 0, 0, 0, 0, 1, 32'hDDDD0001);
        checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b01) begin errors++; $display("[TB] FAIL order_first: got %b want 01", {inst_sram_data_ok, data_sram_data_ok}); end
        checks++; if (data_sram_rdata !== 32'hDDDD0001) begin errors++; $display("[TB] FAIL order_rdata: got %h want dddd0001", data_sram_rdata); end
        tick();
        apply(0, 0, 0, 0, 0, 0, 1, 32'h11110002);
        checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b10) begin errors++; $display("[TB] FAIL order_second: got %b want 10", {inst_sram_data_ok, data_sram_data_ok}); end
        tick();
        drain();
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 9; i++) begin
            apply(1, 32'h1C000100, 1, 32'h2000 + 4 * i, 0, 1, owner_m.size() > 0, i);
            if (i < STARVE_LIMIT) begin
                checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b01) begin errors++; $display("[TB] FAIL starve_data_%0d: got %b want 01", i, {inst_sram_addr_ok, data_sram_addr_ok}); end
            end else begin
                checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b10) begin errors++; $display("[TB] FAIL starve_forced: got %b want 10", {inst_sram_addr_ok, data_sram_addr_ok}); end
            end
            tick();
        end
        apply(1, 32'h1C000104, 1, 32'h2100, 0, 1, 1, 0);
        checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b01) begin errors++; $display("[TB] FAIL starve_cleared: got %b want 01", {inst_sram_addr_ok, data_sram_addr_ok}); end
        tick();
        drain();
    endtask

    task automatic test_full();
        for (int i = 0; i < MAX_OUTST; i++) begin
            apply(0, 0, 1, 32'h3000 + 4 * i, 1, 1, 0, 0);
            checks++; if (data_sram_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL fill_%0d: got %b want 1", i, data_sram_addr_ok); end
            tick();
        end
        apply(0, 0, 1, 32'h3010, 1, 1, 0, 0);
        checks++; if (outst_cnt !== 3'd4) begin errors++; $display("[TB] FAIL full_cnt: got %0d want 4", outst_cnt); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL full_block: got %b want 0", mem_req); end
        tick();
        apply(0, 0, 1, 32'h3010, 1, 1, 1, 32'h5A5A0000);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL full_no_bypass: got %b want 0", mem_req); end
        checks++; if (data_sram_data_ok !== 1'b1) begin errors++; $display("[TB] FAIL full_pop_ok: got %b want 1", data_sram_data_ok); end
        tick();
        apply(0, 0, 1, 32'h3010, 1, 1, 0, 0);
        checks++; if (outst_cnt !== 3'd3) begin errors++; $display("[TB] FAIL full_cnt3: got %0d want 3", outst_cnt); end
        checks++; if (data_sram_addr_ok !== 1'b1) begin errors++; $display("[TB] FAIL full_resume: got %b want 1", data_sram_addr_ok); end
        tick();
        drain();
    endtask

    task automatic test_proto_err();
        apply(0, 0, 0, 0, 0, 0, 1, 32'h0000_0BAD);
        checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin errors++; $display("[TB] FAIL perr_no_ok: got %b want 00", {inst_sram_data_ok, data_sram_data_ok}); end
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL perr_set: got %b want 1", proto_err); end
        tick();
        tick();
        checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL perr_sticky: got %b want 1", proto_err); end
    endtask

    task automatic test_random();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            if (!inst_sram_req && $urandom_range(0, 1) == 1) begin
                inst_sram_req = 1'b1; inst_sram_addr = $urandom; inst_sram_size = 2'($urandom_range(0, 2));
                inst_sram_wstrb = 4'($urandom); inst_sram_wdata = $urandom;
            end
            if (!data_sram_req && $urandom_range(0, 2) != 0) begin
                data_sram_req = 1'b1; data_sram_addr = $urandom; data_sram_wr = 1'($urandom);
                data_sram_size = 2'($urandom_range(0, 2)); data_sram_wstrb = 4'($urandom); data_sram_wdata = $urandom;
            end
            mem_addr_ok = ($urandom_range(0, 3) != 0);
            mem_data_ok = (owner_m.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
            mem_rdata   = $urandom;
            #1;
            model_comb();
            checks++; if (mem_req !== (e_gi || e_gd)) begin errors++; $display("[TB] FAIL rnd_mem_req @%0d: got %b want %b", n, mem_req, e_gi || e_gd); end
            checks++; if (mem_addr !== e_addr) begin errors++; $display("[TB] FAIL rnd_mem_addr @%0d: got %h want %h", n, mem_addr, e_addr); end
            checks++; if ({mem_wr, mem_size, mem_wstrb} !== {e_wr, e_size, e_wstrb}) begin errors++; $display("[TB] FAIL rnd_mem_ctl @%0d: got %h want %h", n, {mem_wr, mem_size, mem_wstrb}, {e_wr, e_size, e_wstrb}); end
            checks++; if (mem_wdata !== e_wdata) begin errors++; $display("[TB] FAIL rnd_mem_wdata @%0d: got %h want %h", n, mem_wdata, e_wdata); end
            checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== {e_iaok, e_daok}) begin errors++; $display("[TB] FAIL rnd_addr_ok @%0d: got %b want %b", n, {inst_sram_addr_ok, data_sram_addr_ok}, {e_iaok, e_daok}); end
            checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== {e_idok, e_ddok}) begin errors++; $display("[TB] FAIL rnd_data_ok @%0d: got %b want %b", n, {inst_sram_data_ok, data_sram_data_ok}, {e_idok, e_ddok}); end
            if (e_idok || e_ddok) begin
                checks++; if ((e_idok ? inst_sram_rdata : data_sram_rdata) !== mem_rdata) begin errors++; $display("[TB] FAIL rnd_rdata @%0d: got %h want %h", n, e_idok ? inst_sram_rdata : data_sram_rdata, mem_rdata); end
            end
            checks++; if (outst_cnt !== 3'(owner_m.size())) begin errors++; $display("[TB] FAIL rnd_cnt @%0d: got %0d want %0d", n, outst_cnt, owner_m.size()); end
            checks++; if (proto_err !== perr_m) begin errors++; $display("[TB] FAIL rnd_proto_err @%0d: got %b want %b", n, proto_err, perr_m); end
            tick();
            if (e_iaok) inst_sram_req = 1'b0;
            if (e_daok) data_sram_req = 1'b0;
        end
        drain();
    endtask

    task automatic test_async_reset();
        apply(0, 0, 1, 32'h4000, 0, 1, 0, 0);
        tick();
        apply(0, 0, 1, 32'h4004, 0, 1, 0, 0);
        tick();
        apply(1, 32'h1C000200, 1, 32'h4008, 0, 1, 0, 0);
        checks++; if (outst_cnt !== 3'd2) begin errors++; $display("[TB] FAIL arst_pre_cnt: got %0d want 2", outst_cnt); end
        #2 resetn = 1'b0;
        #1;
        checks++; if (outst_cnt !== 3'd0) begin errors++; $display("[TB] FAIL arst_cnt: got %0d want 0", outst_cnt); end
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL arst_mem_req: got %b want 0", mem_req); end
        checks++; if ({inst_sram_addr_ok, data_sram_addr_ok} !== 2'b00) begin errors++; $display("[TB] FAIL arst_addr_ok: got %b want 00", {inst_sram_addr_ok, data_sram_addr_ok}); end
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        apply(0, 0, 0, 0, 0, 0, 1, 32'h0BADF00D);
        checks++; if ({inst_sram_data_ok, data_sram_data_ok} !== 2'b00) begin errors++; $display("[TB] FAIL late_data_ok: got %b want 00", {inst_sram_data_ok, data_sram_data_ok}); end
        tick();
        apply(0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (proto_err !== 1'b1) begin errors++; $display("[TB] FAIL late_proto_err: got %b want 1", proto_err); end
    endtask

    initial begin
        resetn = 1'b0;
        inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 0; inst_sram_wstrb = 0;
        inst_sram_addr = 0; inst_sram_wdata = 0;
        data_sram_req = 0; data_sram_wr = 0; data_sram_size = 0; data_sram_wstrb = 0;
        data_sram_addr = 0; data_sram_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
        model_reset();
        $display("[TB] starting sram_req_arbiter checks");
        test_reset();
        test_single_fetch();
        test_priority_order();
        test_starvation();
        test_full();
        test_proto_err();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
